regif_arb: RTL
==============

# regif_arb

Arbiter and multiplexer for the single master register interface (REGIF), shared by the host read accessor (port 0, rd) and the host write accessor (port 1, wr). It offers `my_regif` grants round-robin and locks the grant while the winner holds `drv_regif` high. It routes the owner's IP2Bus master signals onto the shared bus and steers Bus2IP completion strobes back to the owner only. A lock watchdog flags requesters that hold the bus too long.

## Interface
- `GRANT_SLOT`, 4: cycles an unclaimed grant is offered before the gap cycle; legal range 2..255.
- `TIMEOUT`, 32'd65535: cycles in LOCK before `lock_timeout` asserts.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `my_regif` out 2: grant; bit 0 is rd, bit 1 is wr. At most one bit is set.
- `drv_regif` in 2: claim; bit i comes from requester i.
- `rd_MstRd_Req` in 1: read command request from rd.
- `rd_Mst_Addr` in 32: read address from rd.
- `wr_MstWr_Req` in 1: write command request from wr.
- `wr_Mst_Addr` in 32: write address from wr.
- `wr_MstWr_d` in 32: write data from wr.
- `wr_Mst_BE` in 4: byte enables from wr.
- `IP2Bus_MstRd_Req` out 1: shared read request.
- `IP2Bus_MstWr_Req` out 1: shared write request.
- `IP2Bus_Mst_Addr` out 32: shared address.
- `IP2Bus_MstWr_d` out 32: shared write data.
- `IP2Bus_Mst_BE` out 4: shared byte enables.
- `Bus2IP_Mst_CmdAck` in 1, `Bus2IP_Mst_Cmplt` in 1, `Bus2IP_Mst_Error` in 1, `Bus2IP_MstRd_src_rdy_n` in 1: bus responses.
- `rd_CmdAck` out 1, `rd_Cmplt` out 1, `rd_Error` out 1, `rd_src_rdy_n` out 1: steered responses for rd.
- `wr_CmdAck` out 1, `wr_Cmplt` out 1, `wr_Error` out 1: steered responses for wr.
- `lock_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states and outputs:
  - OFFER(i): `my_regif` = 1<<i.
  - GAP(i): `my_regif` = 0.
  - LOCK(i): `my_regif` = 1<<i.
- Slot counter `slot_cnt` is 8 bits. Watchdog counter `lock_cnt` is 32 bits and saturates at all-ones.
- OFFER(i) transitions:
  - `drv_regif[i]`=1 → LOCK(i).
  - Else if `slot_cnt`==GRANT_SLOT-1 → GAP(i).
  - Else `slot_cnt`++.
- GAP(i) lasts exactly 1 cycle. It catches a claim registered from a grant sampled on the last OFFER cycle.
  - `drv_regif[i]`=1 → LOCK(i).
  - Else → OFFER(1-i) with `slot_cnt`=0.
- LOCK(i) transitions:
  - `drv_regif[i]`=0 → OFFER(1-i) with `slot_cnt`=0. This forces round-robin fairness.
  - `lock_cnt` counts every cycle in LOCK. When `lock_cnt`==TIMEOUT, `lock_timeout` is set to 1. It clears only on reset, and the lock is not broken.
  - `lock_cnt` clears on entry to LOCK.
- `drv_regif[1-i]` is ignored while requester i holds the grant or lock. Only the current owner index is examined.
- Mux (combinational from the registered owner `own` and the LOCK state flag):
  - Shared IP2Bus outputs carry the owner's signals only while in LOCK. Otherwise they are all zero.
  - `IP2Bus_Mst_Addr` = `rd_Mst_Addr` in LOCK(0), `wr_Mst_Addr` in LOCK(1), else 0.
  - `IP2Bus_MstRd_Req` is `rd_MstRd_Req` gated by LOCK(0).
  - `IP2Bus_MstWr_Req`, `IP2Bus_MstWr_d` and `IP2Bus_Mst_BE` are the wr signals gated by LOCK(1).
- Response steering:
  - In LOCK(i), the owner's strobes equal the Bus2IP inputs.
  - The non-owner's strobes are 0, and its `src_rdy_n` is 1.
  - Outside LOCK, all strobes are 0 and `rd_src_rdy_n` is 1.

## Timing
- Reset values: state OFFER(0), `slot_cnt`=0, `lock_cnt`=0, `my_regif`=2'b01, `lock_timeout`=0.
  - All IP2Bus outputs are 0.
  - All steered strobes are 0; `rd_src_rdy_n`=1.
- Reset mid-LOCK aborts the lock immediately. The next cycle shows OFFER(0).
- Claim latency: `drv_regif[i]` sampled high in OFFER(i) or GAP(i) → LOCK(i) on the next edge.
- Release latency: `drv_regif[i]` sampled low in LOCK(i) → `my_regif` = 1<<(1-i) on the next edge.
- The request path adds zero cycles. The requester's own Req/CmdAck handshake is unchanged.
- Unclaimed rotation period per requester is GRANT_SLOT+1 cycles.
- Both claims high in the same cycle: only the current owner index is honoured.

## Test plan
- Reset idle: hold `rst_n`=0 for 3 cycles, release, no claims.
  - `my_regif` sequence is 01 ×4, 00, 10 ×4, 00, 01.
  - All IP2Bus outputs are 0.
- rd lock: rd asserts `drv_regif[0]` 1 cycle after first seeing the grant; `rd_Mst_Addr`=32'h0000_0040; `rd_MstRd_Req`=1.
  - Next cycle: LOCK(0), `IP2Bus_Mst_Addr`=32'h40, `IP2Bus_MstRd_Req`=1.
  - `Bus2IP_Mst_CmdAck` appears only on `rd_CmdAck`.
- Gap catch: rd samples the grant on the 4th OFFER cycle and claims in GAP.
  - Result: LOCK(0) with `my_regif` re-asserted to 01; wr never sees the grant.
- Fairness: both requesters claim every opportunity.
  - Owners alternate 0,1,0,1.
  - Each release moves the grant to the other requester on the next edge.
- Watchdog: TIMEOUT=10; rd holds `drv_regif[0]` for 20 cycles.
  - `lock_timeout` rises on the 11th LOCK cycle and stays 1 after release.
- Reset mid-lock: assert `rst_n`=0 during LOCK(1) with `wr_MstWr_Req`=1.
  - Next cycle: `IP2Bus_MstWr_Req`=0, `my_regif`=01, `lock_timeout`=0.

Source files
------------

// File: rtl/regif_arb_if.sv
// regif_arb_if: REGIF claim/grant handshake plus shared IP2Bus/Bus2IP signals
interface regif_arb_if;
  logic [1:0]  my_regif;
  logic [1:0]  drv_regif;
  logic        rd_MstRd_Req;
  logic [31:0] rd_Mst_Addr;
  logic        wr_MstWr_Req;
  logic [31:0] wr_Mst_Addr;
  logic [31:0] wr_MstWr_d;
  logic [3:0]  wr_Mst_BE;
  logic        IP2Bus_MstRd_Req;
  logic        IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [31:0] IP2Bus_MstWr_d;
  logic [3:0]  IP2Bus_Mst_BE;
  logic        Bus2IP_Mst_CmdAck;
  logic        Bus2IP_Mst_Cmplt;
  logic        Bus2IP_Mst_Error;
  logic        Bus2IP_MstRd_src_rdy_n;
  logic        rd_CmdAck;
  logic        rd_Cmplt;
  logic        rd_Error;
  logic        rd_src_rdy_n;
  logic        wr_CmdAck;
  logic        wr_Cmplt;
  logic        wr_Error;
  logic        lock_timeout;
  modport slave (
    output my_regif, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d, IP2Bus_Mst_BE,
           rd_CmdAck, rd_Cmplt, rd_Error, rd_src_rdy_n, wr_CmdAck, wr_Cmplt, wr_Error, lock_timeout,
    input  drv_regif, rd_MstRd_Req, rd_Mst_Addr, wr_MstWr_Req, wr_Mst_Addr, wr_MstWr_d, wr_Mst_BE,
           Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_MstRd_src_rdy_n
  );
  modport master (
    input  my_regif, IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_MstWr_d, IP2Bus_Mst_BE,
           rd_CmdAck, rd_Cmplt, rd_Error, rd_src_rdy_n, wr_CmdAck, wr_Cmplt, wr_Error, lock_timeout,
    output drv_regif, rd_MstRd_Req, rd_Mst_Addr, wr_MstWr_Req, wr_Mst_Addr, wr_MstWr_d, wr_Mst_BE,
           Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_MstRd_src_rdy_n
  );
endinterface

// File: rtl/regif_arb.sv
// regif_arb: round-robin REGIF grant/lock arbiter with bus mux, response steering and lock watchdog
module regif_arb #(
  parameter int          GRANT_SLOT = 4,
  parameter logic [31:0] TIMEOUT    = 32'd65535
) (
  input logic        clk,
  input logic        rst_n,
  regif_arb_if.slave bus
);
  typedef enum logic [1:0] {OFFER, GAP, LOCK} state_t;
  state_t      state, state_nxt;
  logic        own, own_nxt;
  logic [7:0]  slot_cnt, slot_nxt;
  logic [31:0] lock_cnt, lock_nxt;
  logic        timeout, timeout_nxt;
  logic        claim, l0, l1;
  assign claim = bus.drv_regif[own];
  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    slot_nxt  = slot_cnt;
    if (state == OFFER) begin
      if (claim) state_nxt = LOCK;
      else if (slot_cnt == 8'(GRANT_SLOT - 1)) state_nxt = GAP;
      else slot_nxt = slot_cnt + 8'd1;
    end else if (state == GAP && claim) begin
      state_nxt = LOCK;
    end else if (state == GAP || !claim) begin
      state_nxt = OFFER;
      own_nxt   = !own;
      slot_nxt  = '0;
    end
    lock_nxt    = (state_nxt != LOCK) ? lock_cnt : (state != LOCK) ? '0 : (&lock_cnt) ? lock_cnt : lock_cnt + 32'd1;
    timeout_nxt = timeout | (state_nxt == LOCK && lock_nxt == TIMEOUT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OFFER;
      own      <= 1'b0;
      slot_cnt <= '0;
      lock_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      own      <= own_nxt;
      slot_cnt <= slot_nxt;
      lock_cnt <= lock_nxt;
      timeout  <= timeout_nxt;
    end
  end
  assign l0 = state == LOCK && !own;
  assign l1 = state == LOCK && own;
  assign bus.my_regif         = (state == GAP) ? 2'b00 : {own, !own};
  assign bus.IP2Bus_MstRd_Req = l0 & bus.rd_MstRd_Req;
  assign bus.IP2Bus_MstWr_Req = l1 & bus.wr_MstWr_Req;
  assign bus.IP2Bus_Mst_Addr  = l0 ? bus.rd_Mst_Addr : l1 ? bus.wr_Mst_Addr : '0;
  assign bus.IP2Bus_MstWr_d   = l1 ? bus.wr_MstWr_d : '0;
  assign bus.IP2Bus_Mst_BE    = l1 ? bus.wr_Mst_BE : '0;
  assign bus.rd_CmdAck        = l0 & bus.Bus2IP_Mst_CmdAck;
  assign bus.rd_Cmplt         = l0 & bus.Bus2IP_Mst_Cmplt;
  assign bus.rd_Error         = l0 & bus.Bus2IP_Mst_Error;
  assign bus.rd_src_rdy_n     = !l0 | bus.Bus2IP_MstRd_src_rdy_n;
  assign bus.wr_CmdAck        = l1 & bus.Bus2IP_Mst_CmdAck;
  assign bus.wr_Cmplt         = l1 & bus.Bus2IP_Mst_Cmplt;
  assign bus.wr_Error         = l1 & bus.Bus2IP_Mst_Error;
  assign bus.lock_timeout     = timeout;
endmodule
